// File: rtl/em4100_tag_scheduler.sv
// Round-robin arbiter sharing one EM4100 encoder among four tag requesters.
// Each grant sends REPEAT full frames, then holds a quiet gap before re-arbitrating.
module em4100_tag_scheduler #(
   parameter int CLKS_PER_BIT = 2,
   parameter int REPEAT       = 3,
   parameter int GAP_CLKS     = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [3:0]     req,
   input  logic [159:0]   id_flat,
   input  logic           abort,
   output logic           tx,
   output logic [39:0]    data,
   output logic [3:0]     grant,
   output logic [3:0]     ack,
   output logic           busy
);
   localparam int FRAME_CLKS = 64 * CLKS_PER_BIT;
   localparam int SEND_CLKS  = REPEAT * FRAME_CLKS;
   localparam int CNT_MAX    = (SEND_CLKS > GAP_CLKS) ? SEND_CLKS : GAP_CLKS;
   localparam int CW         = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] SEND_LAST = CW'(SEND_CLKS - 1);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CLKS - 1);
   localparam logic [CW-1:0] CNT_SAT   = CW'(CNT_MAX);

   typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [1:0]    rr_ptr, owner, pick;
   logic          pick_vld;
   logic          tx_nx, busy_nx;
   logic [3:0]    ack_nx;

   // Descending scan so the lowest offset from rr_ptr wins.
   always_comb begin
      pick     = rr_ptr;
      pick_vld = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (req[rr_ptr + 2'(i)]) begin
            pick     = rr_ptr + 2'(i);
            pick_vld = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         tx    <= 1'b0;
         busy  <= 1'b0;
         ack   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         tx    <= tx_nx;
         busy  <= busy_nx;
         ack   <= ack_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (pick_vld) state_nx = LOAD;
         LOAD:    state_nx = abort ? GAP : SEND;
         SEND:    if (abort || cnt == SEND_LAST) state_nx = GAP;
         GAP:     if (cnt == GAP_LAST) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Outputs are computed one cycle ahead so every port comes straight from a flop.
   always_comb begin
      cnt_nx  = (state_nx != state) ? '0 :
                (cnt == CNT_SAT)    ? cnt : cnt + CW'(1);
      tx_nx   = (state_nx == SEND);
      busy_nx = (state_nx != IDLE);
      ack_nx  = (state_nx == SEND && cnt_nx == SEND_LAST) ? grant : 4'b0000;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data   <= '0;
         grant  <= '0;
         owner  <= '0;
         rr_ptr <= '0;
      end else begin
         if (state == IDLE && pick_vld) begin
            data  <= id_flat[40*int'(pick) +: 40];
            grant <= 4'b0001 << pick;
            owner <= pick;
         end else if (state == GAP && state_nx == IDLE) begin
            grant <= '0;
         end
         if (state_nx == GAP && state != GAP)
            rr_ptr <= owner + 2'd1;
      end
   end

endmodule

// File: tb/tb_em4100_tag_scheduler.sv
// Bench for em4100_tag_scheduler: vector table, timing sequences and a
// transaction-timeline reference model checked every cycle under random traffic.
`timescale 1ns/1ps
module tb_em4100_tag_scheduler;
   localparam int CPB  = 2;
   localparam int REP  = 3;
   localparam int GAPC = 16;
   localparam int T    = 64 * CPB * REP;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [3:0]   req = '0;
   logic [159:0] id_flat = '0;
   logic         abort = 1'b0;
   logic         tx, busy;
   logic [39:0]  data;
   logic [3:0]   grant, ack;

   int checks = 0;
   int failures = 0;

   em4100_tag_scheduler #(.CLKS_PER_BIT(CPB), .REPEAT(REP), .GAP_CLKS(GAPC)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .id_flat(id_flat), .abort(abort),
      .tx(tx), .data(data), .grant(grant), .ack(ack), .busy(busy)
   );

   always #5 clk = ~clk;

   // Reference model: a grant is a timeline measured from its LOAD cycle (rel=0).
   // tx covers rel 1..gs-1, the gap covers gs..gs+GAPC-1; abort pulls gs in.
   logic        m_act;
   int          m_rel, m_gs;
   logic [1:0]  m_own, m_ptr;
   logic [39:0] m_data;

   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
      for (int i = 0; i < 4; i++)
         if (r[(int'(p) + i) % 4]) return 2'((int'(p) + i) % 4);
      return p;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_act <= 1'b0; m_rel <= 0; m_gs <= T + 1;
         m_own <= '0; m_ptr <= '0; m_data <= '0;
      end else if (!m_act) begin
         if (req != 4'b0) begin
            m_act  <= 1'b1;
            m_rel  <= 0;
            m_gs   <= T + 1;
            m_own  <= rr_pick(req, m_ptr);
            m_ptr  <= rr_pick(req, m_ptr) + 2'd1;
            m_data <= id_flat[40*int'(rr_pick(req, m_ptr)) +: 40];
         end
      end else begin
         if (abort && m_rel < m_gs) m_gs <= m_rel + 1;
         if (m_rel == m_gs + GAPC - 1) m_act <= 1'b0;
         else m_rel <= m_rel + 1;
      end
   end

   function automatic logic [49:0] exp_vec();
      logic [3:0] oh;
      oh = 4'b0001 << m_own;
      return {m_act && m_rel >= 1 && m_rel < m_gs, m_act,
              m_act ? oh : 4'b0000,
              (m_act && m_rel == T && m_gs == T + 1) ? oh : 4'b0000,
              m_data};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s: timed out (t=%0t)", name, $time);
   endtask

   // Every stimulus step goes through here so the model is compared each cycle.
   task automatic tick();
      @(negedge clk);
      chk("model", 64'({tx, busy, grant, ack, data}), 64'(exp_vec()));
   endtask

   task automatic wait_grant(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
         tick();
         if (grant != 4'b0) begin ok = 1'b1; break; end
      end
      if (!ok) timeout("wait_grant");
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < T + GAPC + 20; n++) begin
         if (!busy) begin ok = 1'b1; break; end
         tick();
      end
      if (!ok) timeout("wait_idle");
   endtask

   // One full grant: check the owner, withdraw req a cycle later, count tx/ack.
   task automatic run_grant(input logic [3:0] r, input int own, input string tag);
      bit ok;
      int txc, ackc;
      logic stable;
      logic [39:0] d0;
      tick();
      req = r;
      wait_grant(ok);
      chk({tag, "_grant"}, 64'(grant), 64'(4'b0001 << own));
      chk({tag, "_data"}, 64'(data), 64'(id_flat[40*own +: 40]));
      tick();
      req = 4'b0;
      txc = 0; ackc = 0; stable = 1'b1; d0 = data;
      for (int n = 0; n < T + GAPC + 10 && busy; n++) begin
         if (tx) begin
            txc++;
            if (data !== d0) stable = 1'b0;
         end
         if (ack == (4'b0001 << own)) ackc++;
         else if (ack != 4'b0) ackc += 100;
         tick();
      end
      chk({tag, "_tx_cycles"}, 64'(txc), 64'(T));
      chk({tag, "_acks"}, 64'(ackc), 64'(1));
      chk({tag, "_data_stable"}, 64'(stable), 64'(1));
      chk({tag, "_idle"}, 64'(busy), 64'(0));
   endtask

   typedef struct {
      logic [3:0] req;
      int         owner;
   } vec_t;

   vec_t vecs[10];

   initial begin
      bit ok;
      int gapc, ackc;

      // rr_ptr is 1 on entry to the table (after serving requester 0).
      vecs[0] = '{4'b0001, 0};
      vecs[1] = '{4'b1011, 1};
      vecs[2] = '{4'b1011, 3};
      vecs[3] = '{4'b1011, 0};
      vecs[4] = '{4'b1000, 3};
      vecs[5] = '{4'b1001, 0};
      vecs[6] = '{4'b0100, 2};
      vecs[7] = '{4'b0110, 1};
      vecs[8] = '{4'b1111, 2};
      vecs[9] = '{4'b0011, 0};

      id_flat = {40'h1234567890, 40'hA5A5A5A5A5, 40'hDEADBEEF01, 40'h5555555555};

      tick();
      tick();
      chk("reset_outputs", 64'({tx, busy, grant, ack, data}), 64'(0));
      rst_n = 1'b1;
      tick();
      chk("post_reset_idle", 64'({tx, busy, grant}), 64'(0));

      // Single request, cycle-exact timing; req withdrawn at cycle 2.
      req = 4'b0001;
      for (int n = 1; n <= 404; n++) begin
         tick();
         if (n == 1) chk("single_data_c1", 64'(data), 64'(40'h5555555555));
         if (n == 2) req = 4'b0;
         chk("single_timing", 64'({tx, ack, busy}),
             64'({n >= 2 && n <= 385, (n == 385) ? 4'b0001 : 4'b0000, n >= 1 && n <= 401}));
      end

      for (int v = 0; v < 10; v++)
         run_grant(vecs[v].req, vecs[v].owner, $sformatf("vec%0d", v));

      // Abort at SEND cycle 100.
      tick();
      req = 4'b0001;
      wait_grant(ok);
      chk("abort_grant", 64'(grant), 64'(4'b0001));
      tick();
      req = 4'b0;
      chk("abort_send0_tx", 64'(tx), 64'(1));
      for (int n = 0; n < 100; n++) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_tx_drop", 64'(tx), 64'(0));
      gapc = 0; ackc = 0;
      for (int n = 0; n < 40 && busy; n++) begin
         if (!tx) gapc++;
         if (ack != 4'b0) ackc++;
         tick();
      end
      chk("abort_gap_len", 64'(gapc), 64'(GAPC));
      chk("abort_no_ack", 64'(ackc), 64'(0));
      run_grant(4'b1111, 1, "abort_ptr");

      // Asynchronous reset in the middle of SEND, then re-grant of a held req[2].
      tick();
      req = 4'b0100;
      wait_grant(ok);
      chk("areset_grant", 64'(grant), 64'(4'b0100));
      for (int n = 0; n < 50; n++) tick();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk("areset_async", 64'({tx, grant, busy, ack}), 64'(0));
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("areset_regrant_load", 64'({grant, tx}), 64'({4'b0100, 1'b0}));
      tick();
      chk("areset_regrant_tx", 64'(tx), 64'(1));
      req = 4'b0;
      wait_idle();

      // Random traffic against the model.
      for (int n = 0; n < 5000; n++) begin
         tick();
         if ($urandom_range(0, 39) == 0) req = 4'($urandom_range(0, 15));
         abort = ($urandom_range(0, 119) == 0);
         if ($urandom_range(0, 79) == 0)
            id_flat = {$urandom, $urandom, $urandom, $urandom, $urandom};
      end
      abort = 1'b0;
      req = 4'b0;
      tick();
      wait_idle();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
